shift_cmd_pipeline: RTL and testbench

- Registered command/result stage that wraps the combinational multi-direction barrel shifter.
- Buffers shift commands (operand, amount, direction) in a small FIFO and presents the head command to the shifter.
- Captures the shifter result into an output register with a valid/ready handshake.
- Lets upstream producers and downstream consumers stall independently of the shifter.

---
 rtl/shift_cmd_pipeline.sv | 122 ++++++++++++
 tb/tb_shift_cmd_pipeline.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_pipeline.sv
// shift_cmd_pipeline
//   Registered command/result stage around an external combinational barrel
//   shifter. Shift commands (operand, amount, direction) are queued in a
//   DEPTH-entry FIFO. The head command is presented to the shifter, and the
//   shifter result is captured in an output register with a valid/ready
//   handshake. Producer and consumer can stall independently.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     command handshake (in_ready = FIFO not full)
//   in_a, in_amt, in_lr   command: operand, shift amount, 1=left / 0=right
//   sh_a, sh_amt, sh_lr   head command driven to the shifter (0 when empty)
//   sh_y                  combinational shifter result
//   out_valid/out_ready   result handshake
//   out_y                 registered result
//   fifo_count            number of occupied FIFO entries
module shift_cmd_pipeline #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [$clog2(N)-1:0]       in_amt,
  input  logic                       in_lr,
  output logic [N-1:0]               sh_a,
  output logic [$clog2(N)-1:0]       sh_amt,
  output logic                       sh_lr,
  input  logic [N-1:0]               sh_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_y,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Command storage. Not reset: only entries between rd and wr are ever read.
  logic [N-1:0]  a_mem   [DEPTH];
  logic [AW-1:0] amt_mem [DEPTH];
  logic          lr_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_p0;
  logic [PW-1:0] rd_ptr_p0;
  logic [CW-1:0] cnt_p0;
  logic [N-1:0]  y_p1;
  logic          vld_p1;

  logic push;
  logic load;
  logic fifo_empty;

  // in_ready depends on occupancy only; a pop in the same cycle does not
  // open a slot for the push (no lookahead).
  assign in_ready   = (cnt_p0 != CW'(DEPTH));
  assign fifo_empty = (cnt_p0 == '0);
  assign push       = in_valid & in_ready;
  // The output register may take a new result when it is free or is being
  // emptied this cycle. A command pushed this cycle is not yet visible.
  assign load       = !fifo_empty & (!vld_p1 | out_ready);

  // ---- stage p0: command FIFO ----
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_p0]   <= in_a;
      amt_mem[wr_ptr_p0] <= in_amt;
      lr_mem[wr_ptr_p0]  <= in_lr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (load) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({push, load})
        2'b10:   cnt_p0 <= cnt_p0 + 1'b1;
        2'b01:   cnt_p0 <= cnt_p0 - 1'b1;
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // Head command to the shifter; zeros when nothing is queued.
  always_comb begin
    sh_a   = '0;
    sh_amt = '0;
    sh_lr  = 1'b0;
    if (!fifo_empty) begin
      sh_a   = a_mem[rd_ptr_p0];
      sh_amt = amt_mem[rd_ptr_p0];
      sh_lr  = lr_mem[rd_ptr_p0];
    end
  end

  // ---- stage p1: result register ----
  // When draining with nothing to reload, only valid drops; the data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else if (load) begin
      y_p1   <= sh_y;
      vld_p1 <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_y      = y_p1;
  assign out_valid  = vld_p1;
  assign fifo_count = cnt_p0;

endmodule

// File: tb/tb_shift_cmd_pipeline.sv
// Testbench for shift_cmd_pipeline: loops the shifter ports to a rotate
// model, runs directed scenarios with literal expectations, and compares
// every cycle against a queue-based behavioural model.
module tb_shift_cmd_pipeline;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [2:0] in_amt = '0;
  logic       in_lr = 1'b0;
  logic [7:0] sh_a;
  logic [2:0] sh_amt;
  logic       sh_lr;
  logic [7:0] sh_y;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int hs = 0;
  logic acc;

  shift_cmd_pipeline #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_amt(in_amt), .in_lr(in_lr),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_lr(sh_lr), .sh_y(sh_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Shifter stand-in: rotate left when lr=1, rotate right otherwise.
  assign sh_y = sh_lr ? ((sh_a << sh_amt) | (sh_a >> (4'd8 - {1'b0, sh_amt})))
                      : ((sh_a >> sh_amt) | (sh_a << (4'd8 - {1'b0, sh_amt})));

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic       lr;
  } cmd_t;

  // Bit-by-bit rotation used by the model.
  function automatic logic [7:0] rot_ref(input cmd_t c);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (c.lr) r[(j + c.amt) % 8] = c.a[j];
      else      r[j] = c.a[(j + c.amt) % 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of commands and an output slot.
  cmd_t       mq[$];
  logic       m_vld = 1'b0;
  logic [7:0] m_y = '0;

  initial begin
    bit m_push, m_load;
    cmd_t c;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_vld = 1'b0;
        m_y   = '0;
      end else begin
        m_push = in_valid && (mq.size() != DEPTH);
        m_load = (mq.size() != 0) && (!m_vld || out_ready);
        if (m_load) begin
          c = mq.pop_front();
          m_y = rot_ref(c);
          m_vld = 1'b1;
        end else if (m_vld && out_ready) begin
          m_vld = 1'b0;
        end
        if (m_push) mq.push_back('{a: in_a, amt: in_amt, lr: in_lr});
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_out_valid", out_valid, m_vld);
      check("m_out_y", out_y, m_y);
      check("m_fifo_count", fifo_count, mq.size());
      check("m_in_ready", in_ready, mq.size() != DEPTH);
      if (mq.size() != 0) begin
        check("m_sh_a", sh_a, mq[0].a);
        check("m_sh_amt", sh_amt, mq[0].amt);
        check("m_sh_lr", sh_lr, mq[0].lr);
      end else begin
        check("m_sh_idle", {sh_a, sh_amt, sh_lr}, 0);
      end
    end
  end

  always @(posedge clk) if (!reset && out_valid && out_ready) hs <= hs + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] DRAIN_EXP [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

  initial begin
    int sent;
    int hs0;
    int c;
    // Reset state
    #12 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_out_y", out_y, 0);
    check("rst_in_ready", in_ready, 1);
    step();

    // Single command
    in_valid = 1; in_a = 8'b1001_0110; in_amt = 3; in_lr = 1; out_ready = 1;
    step();
    in_valid = 0;
    check("single_not_yet", out_valid, 0);
    check("single_count1", fifo_count, 1);
    step();
    check("single_valid", out_valid, 1);
    check("single_y", out_y, 8'b1011_0100);
    check("single_count0", fifo_count, 0);
    step();
    check("single_drained", out_valid, 0);

    // Fill with out_ready low; sixth push must be refused
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_a = 8'h01; in_amt = 3'(i); in_lr = 1;
      step();
    end
    in_valid = 0;
    check("fill_count", fifo_count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_valid", out_valid, 1);
    check("fill_y", out_y, 8'h01);
    step();
    check("fill_hold_y", out_y, 8'h01);

    // Drain in order
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_y", out_y, DRAIN_EXP[i]);
      step();
    end
    check("drain_done", out_valid, 0);
    check("drain_y_hold", out_y, 8'h10);

    // Streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = 8'h80; in_amt = 1; in_lr = 0;
      step();
      if (i >= 1) begin
        check("stream_valid", out_valid, 1);
        check("stream_y", out_y, 8'h40);
      end
      check("stream_count_le1", fifo_count <= 1, 1);
    end
    in_valid = 0;
    step();
    check("stream_last_valid", out_valid, 1);
    check("stream_last_y", out_y, 8'h40);
    step();
    check("stream_end", out_valid, 0);

    // Back-pressure toggle with distinct commands
    hs0 = hs;
    sent = 0;
    c = 0;
    while (c < 100 && sent < 8) begin
      in_valid = 1; in_a = 8'(sent * 37 + 5); in_amt = 3'(sent); in_lr = sent[0];
      out_ready = c[0];
      acc = in_ready;
      step();
      if (acc) sent++;
      c++;
    end
    check("bp_all_sent", sent, 8);
    in_valid = 0;
    out_ready = 1;
    c = 0;
    while (c < 20 && (fifo_count != 0 || out_valid)) begin
      step();
      c++;
    end
    check("bp_drained", {fifo_count, out_valid}, 0);
    check("bp_handshakes", hs - hs0, 8);

    // Async reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = 8'(8'h11 * (i + 1)); in_amt = 3'(i); in_lr = 1;
      step();
    end
    in_valid = 0;
    check("mid_count", fifo_count, 3);
    check("mid_valid", out_valid, 1);
    check("mid_y", out_y, 8'h11);
    #3 reset = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_y", out_y, 0);
    check("arst_in_ready", in_ready, 1);
    step();
    reset = 0;
    step();
    check("post_rst_count", fifo_count, 0);
    check("post_rst_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
